// File: rtl/injector_timing_gen.sv
// injector_timing_gen: peak-and-hold fuel injector timing generator; ports i_clk/i_rst, i_start/i_abort, commands W/P/H/D in, o_enable/o_busy window plus o_peak/o_hold/o_period/o_done events out
module injector_timing_gen #(
  parameter int CNT_W = 16,
  parameter int PWM_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_pulse_width,
  input  logic [CNT_W-1:0] i_peak_time,
  input  logic [PWM_W-1:0] i_hold_period,
  input  logic [PWM_W-1:0] i_hold_on,
  output logic             o_enable,
  output logic             o_peak,
  output logic             o_hold,
  output logic             o_period,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, PEAK, HOLD} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_w, r_p, r_e;
  logic [PWM_W-1:0] r_h, r_d, r_k;
  logic r_enable, r_peak, r_hold, r_period, r_done;
  logic w_ld, w_run, w_go, w_in_hold, w_enter, w_pwm;
  logic [CNT_W-1:0] w_w, w_p, w_ne;
  logic [PWM_W-1:0] w_h, w_d, w_kn;
  assign w_ld = r_state == IDLE && i_start && !i_abort && i_pulse_width != '0;
  assign w_run = r_state != IDLE && !i_abort && r_e != r_w;
  assign w_go = w_ld || w_run;
  assign w_w = w_ld ? i_pulse_width : r_w;
  assign w_p = w_ld ? i_peak_time : r_p;
  assign w_h = w_ld ? i_hold_period : r_h;
  assign w_d = w_ld ? i_hold_on : r_d;
  // e never passes W, so it cannot overflow even at the maximum pulse width
  assign w_ne = w_ld ? CNT_W'(1) : r_e + CNT_W'(1);
  assign w_in_hold = w_ne > w_p;
  assign w_enter = w_in_hold && r_state != HOLD;
  assign w_kn = (w_enter || w_h == '0 || r_k == w_h - PWM_W'(1)) ? '0 : r_k + PWM_W'(1);
  assign w_pwm = w_go && w_in_hold && w_h != '0;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_w <= '0;
      r_p <= '0;
      r_h <= '0;
      r_d <= '0;
      r_e <= '0;
      r_k <= '0;
      r_enable <= 1'b0;
      r_peak <= 1'b0;
      r_hold <= 1'b0;
      r_period <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_ld) begin
        r_w <= i_pulse_width;
        r_p <= i_peak_time;
        r_h <= i_hold_period;
        r_d <= i_hold_on;
      end
      r_state <= w_go ? (w_in_hold ? HOLD : PEAK) : IDLE;
      r_e <= w_go ? w_ne : '0;
      r_k <= (w_go && w_in_hold) ? w_kn : '0;
      r_enable <= w_go;
      r_peak <= w_go && w_ne == w_p && w_p != '0 && w_p < w_w;
      r_period <= w_pwm && w_kn == '0;
      r_hold <= w_pwm && w_kn == w_d;
      r_done <= r_state != IDLE && !i_abort && r_e == r_w;
    end
  end
  assign o_enable = r_enable;
  assign o_busy = r_enable;
  assign o_peak = r_peak;
  assign o_hold = r_hold;
  assign o_period = r_period;
  assign o_done = r_done;
endmodule

// File: tb/tb_injector_timing_gen.sv
// tb_injector_timing_gen: scoreboard bench for injector_timing_gen against a cycle-level behavioural model
module tb_injector_timing_gen;
  logic clk = 1'b0;
  logic i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0;
  logic [15:0] i_pulse_width = '0, i_peak_time = '0;
  logic [7:0] i_hold_period = '0, i_hold_on = '0;
  logic o_enable, o_peak, o_hold, o_period, o_busy, o_done;
  int n_chk = 0, n_fail = 0;
  logic [5:0] q[$];
  bit m_act = 0;
  int m_e, m_w, m_p, m_h, m_d;

  always #5 clk = ~clk;

  injector_timing_gen dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_pulse_width(i_pulse_width), .i_peak_time(i_peak_time),
    .i_hold_period(i_hold_period), .i_hold_on(i_hold_on),
    .o_enable(o_enable), .o_peak(o_peak), .o_hold(o_hold),
    .o_period(o_period), .o_busy(o_busy), .o_done(o_done)
  );

  function automatic logic [5:0] outs();
    return {o_enable, o_peak, o_hold, o_period, o_busy, o_done};
  endfunction

  // outputs expected in the cycle whose elapsed count is e
  function automatic logic [5:0] window(int e);
    logic pk, hd, pr;
    int k;
    pk = m_p >= 1 && m_p < m_w && e == m_p;
    hd = 0;
    pr = 0;
    if (e > m_p && m_h != 0) begin
      k = (e - m_p - 1) % m_h;
      pr = k == 0;
      hd = k == m_d;
    end
    return {1'b1, pk, hd, pr, 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got %b required %b", name, $time, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit ab, input int w, input int p, input int h, input int d);
    logic [5:0] exp;
    @(negedge clk);
    i_rst = rst;
    i_start = st;
    i_abort = ab;
    i_pulse_width = 16'(w);
    i_peak_time = 16'(p);
    i_hold_period = 8'(h);
    i_hold_on = 8'(d);
    if (rst) begin
      m_act = 0;
      exp = '0;
    end else if (m_act && ab) begin
      m_act = 0;
      exp = '0;
    end else if (m_act && m_e == m_w) begin
      m_act = 0;
      exp = 6'b000001;
    end else if (m_act) begin
      m_e++;
      exp = window(m_e);
    end else if (st && !ab && w != 0) begin
      m_act = 1;
      m_w = w;
      m_p = p;
      m_h = h;
      m_d = d;
      m_e = 1;
      exp = window(1);
    end else exp = '0;
    q.push_back(exp);
    if (rst) begin
      #1;
      check("async_reset", outs(), 6'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, $urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 9), $urandom_range(0, 9));
  endtask

  initial begin
    logic [5:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp = q.pop_front();
        check("outputs", outs(), exp);
      end
    end
  end

  initial begin
    #1;
    check("reset_state", outs(), 6'b0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 5, 1, 2, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 20, 5, 4, 1);
    idle(25);
    step(0, 1, 0, 3, 10, 4, 1);
    idle(6);
    step(0, 1, 0, 50, 5, 4, 2);
    idle(11);
    step(0, 0, 1, 50, 5, 4, 2);
    idle(5);
    step(0, 1, 0, 0, 5, 4, 1);
    idle(3);
    step(0, 1, 0, 20, 5, 4, 1);
    idle(4);
    step(0, 1, 0, 9, 2, 3, 0);
    idle(20);
    step(0, 1, 1, 20, 5, 4, 1);
    idle(3);
    step(0, 1, 0, 30, 5, 4, 1);
    idle(14);
    step(1, 0, 0, 30, 5, 4, 1);
    step(0, 0, 0, 30, 5, 4, 1);
    step(0, 1, 0, 30, 5, 4, 1);
    idle(32);
    step(0, 1, 0, 4, 0, 2, 0);
    idle(4);
    step(0, 1, 0, 4, 0, 2, 0);
    idle(6);
    step(0, 1, 0, 12, 0, 3, 5);
    idle(13);
    step(0, 1, 0, 10, 10, 2, 1);
    idle(11);
    step(0, 1, 0, 12, 2, 0, 0);
    idle(13);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 40), $urandom_range(0, 45), $urandom_range(0, 8), $urandom_range(0, 9));
    step(0, 0, 0, 0, 0, 0, 0);
    idle(45);
    step(0, 1, 0, 65535, 100, 255, 254);
    idle(65537);
    idle(3);
    @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
